weight_req_sequencer: RTL and testbench

- Upstream request generator for the weight memory path. Walks one layer's output-channel pairs (od1, od1+1) and input-channel index (id).
- Issues one weight-fetch request per (od-pair, id) step to the weight controller.
- Waits for the weight tile to land (weight valid returned), then waits for the PE arrays to finish consuming it before advancing.
- Sits between the main layer controller (start/config) and the weight memory controller top.

---
 rtl/weight_req_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_weight_req_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_req_sequencer.sv
// weight_req_sequencer: walks one layer's output-channel pairs (od1, od1+1) and
// input-channel index, issuing one weight-fetch request per step. After each
// request it waits for the weight tile to land, then for the PE arrays to
// consume it, before it advances.
//
// Optional feature, macro WREQ_TIMEOUT_EN: when the weight tile does not arrive
// within TIMEOUT cycles (TIMEOUT must be >= 1), the same request is re-issued
// and err_o is set. err_o stays set until reset or the next accepted start.
// With the macro undefined, WAIT_W waits indefinitely and err_o is tied to 0.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start_i; the layer configuration is latched here
// ISSUE   | one-cycle weight_main_valid_o pulse for the current (od, id)
// WAIT_W  | waiting for the weight tile (weight_ack_i)
// WAIT_PE | waiting for the PE arrays to release the tile (pe_done_i)
// DONE    | one-cycle done_o pulse, then back to IDLE
//
// All outputs are registered from the next-state value. A start accepted at
// edge N therefore shows weight_main_valid_o in the cycle right after edge N.

module weight_req_sequencer #(
    parameter int unsigned OD_W    = 8,
    parameter int unsigned ID_W    = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic [OD_W-1:0] total_od_i,
    input  logic [ID_W:0]   total_id_i,
    input  logic            weight_ack_i,
    input  logic            pe_done_i,
    output logic [OD_W-1:0] total_od_o,
    output logic [OD_W-1:0] weight_od1_o,
    output logic [ID_W-1:0] weight_id_o,
    output logic            weight_main_valid_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT_W  = 3'd2,
        WAIT_PE = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t state_q, state_d;

    // od carries one spare bit so that od+2 past total_od=255 cannot wrap;
    // id carries one spare bit so that total_id=16 can be reached.
    logic [OD_W:0]   od_q, od_d;
    logic [ID_W:0]   id_q, id_d;
    logic [OD_W-1:0] tot_od_q, tot_od_d;
    logic [ID_W:0]   tot_id_q, tot_id_d;

    logic [OD_W:0]   od_step;
    logic [ID_W:0]   id_step;
    logic            start_acc;
    logic            timeout_hit;

    // Next-state and loop-counter logic.
    always_comb begin
        state_d   = state_q;
        od_d      = od_q;
        id_d      = id_q;
        tot_od_d  = tot_od_q;
        tot_id_d  = tot_id_q;
        start_acc = 1'b0;
        id_step   = id_q + 1'b1;
        od_step   = od_q + (OD_W+1)'(2);

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    start_acc = 1'b1;
                    tot_od_d  = total_od_i;
                    tot_id_d  = total_id_i;
                    od_d      = '0;
                    id_d      = '0;
                    if ((total_od_i == '0) || (total_id_i == '0)) begin
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end

            ISSUE: begin
                state_d = WAIT_W;
            end

            WAIT_W: begin
                // A pe_done_i arriving together with the ack is dropped here;
                // upstream always sends pe_done after the ack.
                if (weight_ack_i) begin
                    state_d = WAIT_PE;
                end else if (timeout_hit) begin
                    state_d = ISSUE;
                end
            end

            WAIT_PE: begin
                if (pe_done_i) begin
                    if (id_step < tot_id_q) begin
                        id_d    = id_step;
                        state_d = ISSUE;
                    end else begin
                        id_d = '0;
                        od_d = od_step;
                        // Termination relies on the compare, never on overflow.
                        if (od_step < {1'b0, tot_od_q}) begin
                            state_d = ISSUE;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with loop counters and latched layer configuration.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            od_q     <= '0;
            id_q     <= '0;
            tot_od_q <= '0;
            tot_id_q <= '0;
        end else begin
            state_q  <= state_d;
            od_q     <= od_d;
            id_q     <= id_d;
            tot_od_q <= tot_od_d;
            tot_id_q <= tot_id_d;
        end
    end

    // Registered outputs; od1/id only move when a new request is issued, so
    // they stay stable through WAIT_W, WAIT_PE and DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            total_od_o          <= '0;
            weight_od1_o        <= '0;
            weight_id_o         <= '0;
            weight_main_valid_o <= 1'b0;
            busy_o              <= 1'b0;
            done_o              <= 1'b0;
        end else begin
            total_od_o          <= tot_od_d;
            weight_main_valid_o <= (state_d == ISSUE);
            busy_o              <= (state_d != IDLE);
            done_o              <= (state_d == DONE);
            if (state_d == ISSUE) begin
                weight_od1_o <= od_d[OD_W-1:0];
                weight_id_o  <= id_d[ID_W-1:0];
            end
        end
    end

`ifdef WREQ_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TO_W-1:0] to_cnt_q;
    logic            err_q;

    // The counter sits at zero outside WAIT_W, so every entry starts from zero.
    assign timeout_hit = (state_q == WAIT_W) && (to_cnt_q == TO_W'(TIMEOUT - 1));
    assign err_o       = err_q;

    // Count cycles spent in WAIT_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else if (state_q != WAIT_W) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    // Sticky error flag, cleared by reset or a newly accepted layer.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (start_acc) begin
            err_q <= 1'b0;
        end else if (timeout_hit && !weight_ack_i) begin
            err_q <= 1'b1;
        end
    end
`else
    logic timeout_unused;

    assign timeout_hit    = 1'b0;
    assign err_o          = 1'b0;
    assign timeout_unused = (TIMEOUT == 0) | start_acc;
`endif

endmodule

// File: tb/tb_weight_req_sequencer.sv
// Self-checking bench for weight_req_sequencer. Expected (od1, id) requests
// are queued when a layer is started and popped as request pulses appear.
module tb_weight_req_sequencer;

    logic       clk;
    logic       reset;
    logic       start_i;
    logic [7:0] total_od_i;
    logic [4:0] total_id_i;
    logic       weight_ack_i;
    logic       pe_done_i;
    logic [7:0] total_od_o;
    logic [7:0] weight_od1_o;
    logic [3:0] weight_id_o;
    logic       weight_main_valid_o;
    logic       busy_o;
    logic       done_o;
    logic       err_o;

    typedef struct packed {
        logic [7:0] od;
        logic [3:0] id;
    } req_t;

    req_t exp_q[$];

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int n_req = 0;
    int n_done = 0;
    int last_req_cyc = 0;
    int prev_req_cyc = 0;
    int done_cyc = 0;
    int last_pe_edge = 0;
    logic auto_resp = 1'b0;

    weight_req_sequencer #(
        .OD_W(8),
        .ID_W(4),
        .TIMEOUT(8)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .start_i             (start_i),
        .total_od_i          (total_od_i),
        .total_id_i          (total_id_i),
        .weight_ack_i        (weight_ack_i),
        .pe_done_i           (pe_done_i),
        .total_od_o          (total_od_o),
        .weight_od1_o        (weight_od1_o),
        .weight_id_o         (weight_id_o),
        .weight_main_valid_o (weight_main_valid_o),
        .busy_o              (busy_o),
        .done_o              (done_o),
        .err_o               (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Request / done monitor, sampling away from the active edge.
    always @(negedge clk) begin
        if (weight_main_valid_o) begin
            req_t r;
            n_req++;
            prev_req_cyc = last_req_cyc;
            last_req_cyc = cyc;
            chk("req_expected", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                r = exp_q.pop_front();
                chk("req_od1", weight_od1_o, r.od);
                chk("req_id", weight_id_o, r.id);
            end
        end
        if (done_o) begin
            n_done++;
            done_cyc = cyc;
        end
    end

    // Auto responder: ack 3 cycles after each request, pe_done 5 cycles after ack.
    initial begin
        weight_ack_i = 1'b0;
        pe_done_i    = 1'b0;
        forever begin
            @(negedge clk);
            if (auto_resp && weight_main_valid_o) begin
                repeat (2) @(posedge clk);
                #1 weight_ack_i = 1'b1;
                @(posedge clk);
                #1 weight_ack_i = 1'b0;
                repeat (4) @(posedge clk);
                #1 pe_done_i = 1'b1;
                last_pe_edge = cyc + 1;
                @(posedge clk);
                #1 pe_done_i = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int od, input int id);
        req_t r;
        total_od_i = 8'(od);
        total_id_i = 5'(id);
        for (int o = 0; o < od; o += 2) begin
            for (int i = 0; i < id; i++) begin
                r.od = 8'(o);
                r.id = 4'(i);
                exp_q.push_back(r);
            end
        end
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic wait_req(input int budget);
        int n0;
        logic got;
        n0  = n_req;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (n_req != n0) begin
                got = 1'b1;
                break;
            end
        end
        chk("req_seen", got, 1);
    endtask

    task automatic wait_done(input int budget);
        logic got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (done_o) begin
                got = 1'b1;
                break;
            end
        end
        chk("done_seen", got, 1);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_valid"}, weight_main_valid_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_od1"}, weight_od1_o, 0);
        chk({tag, "_id"}, weight_id_o, 0);
        chk({tag, "_tot_od"}, total_od_o, 0);
        chk({tag, "_err"}, err_o, 0);
    endtask

    initial begin
        int req0;
        int done0;

        reset      = 1'b1;
        start_i    = 1'b0;
        total_od_i = '0;
        total_id_i = '0;
        repeat (3) step();
        reset = 1'b0;
        @(negedge clk);
        chk_idle_outputs("rst");

        // Reset mid-layer while in WAIT_PE.
        step();
        auto_resp = 1'b0;
        do_start(4, 2);
        wait_req(10);
        step();
        weight_ack_i = 1'b1;
        step();
        weight_ack_i = 1'b0;
        step();
        chk("midrst_busy_before", busy_o, 1);
        reset = 1'b1;
        exp_q.delete();
        step();
        reset = 1'b0;
        @(negedge clk);
        chk_idle_outputs("midrst");

        // 4 x 2 layer with the auto responder, exact order and done timing.
        step();
        auto_resp = 1'b1;
        req0  = n_req;
        done0 = n_done;
        do_start(4, 2);
        @(negedge clk);
        #1;
        chk("start_to_req", weight_main_valid_o, 1);
        chk("tot_od_latched", total_od_o, 4);
        wait_done(200);
        chk("l42_done_after_pe", done_cyc, last_pe_edge);
        @(negedge clk);
        chk("l42_done_pulse", done_o, 0);
        chk("l42_busy_after", busy_o, 0);
        repeat (3) step();
        chk("l42_nreq", n_req - req0, 4);
        chk("l42_ndone", n_done - done0, 1);
        chk("l42_od1_held", weight_od1_o, 2);
        chk("l42_id_held", weight_id_o, 1);

        // Odd total_od: 3 x 1.
        req0  = n_req;
        do_start(3, 1);
        wait_done(200);
        repeat (2) step();
        chk("l31_nreq", n_req - req0, 2);

        // Zero-size layers: done without any request, busy for one cycle.
        req0  = n_req;
        auto_resp = 1'b0;
        do_start(0, 3);
        @(negedge clk);
        chk("z0_done", done_o, 1);
        chk("z0_busy", busy_o, 1);
        @(negedge clk);
        chk("z0_done_low", done_o, 0);
        chk("z0_busy_low", busy_o, 0);
        step();
        do_start(6, 0);
        @(negedge clk);
        chk("z1_done", done_o, 1);
        chk("z1_busy", busy_o, 1);
        @(negedge clk);
        chk("z1_busy_low", busy_o, 0);
        chk("z_nreq", n_req - req0, 0);

        // Spurious pe_done in WAIT_W, ack in WAIT_PE, start held high.
        step();
        req0  = n_req;
        done0 = n_done;
        total_od_i = 8'd2;
        total_id_i = 5'd1;
        exp_q.push_back(req_t'{od: 8'd0, id: 4'd0});
        start_i = 1'b1;
        wait_req(10);
        step();
        pe_done_i = 1'b1;
        step();
        pe_done_i = 1'b0;
        repeat (3) step();
        chk("spur_pe_busy", busy_o, 1);
        chk("spur_pe_ndone", n_done - done0, 0);
        weight_ack_i = 1'b1;
        step();
        weight_ack_i = 1'b0;
        weight_ack_i = 1'b1;
        step();
        weight_ack_i = 1'b0;
        repeat (3) step();
        chk("spur_ack_ndone", n_done - done0, 0);
        chk("spur_ack_busy", busy_o, 1);
        pe_done_i = 1'b1;
        step();
        pe_done_i = 1'b0;
        chk("spur_done", done_o, 1);
        start_i = 1'b0;
        repeat (3) step();
        chk("spur_nreq", n_req - req0, 1);

        // Boundary sizes: total_od=255 and total_id=16.
        auto_resp = 1'b1;
        req0 = n_req;
        do_start(255, 1);
        wait_done(3000);
        repeat (2) step();
        chk("l255_nreq", n_req - req0, 128);
        chk("l255_last_od1", weight_od1_o, 254);
        req0 = n_req;
        do_start(2, 16);
        wait_done(400);
        repeat (2) step();
        chk("id16_nreq", n_req - req0, 16);
        chk("id16_last_id", weight_id_o, 15);
        auto_resp = 1'b0;

`ifdef WREQ_TIMEOUT_EN
        // Withheld ack: same request re-issued 8 cycles after entering WAIT_W.
        done0 = n_done;
        exp_q.push_back(req_t'{od: 8'd0, id: 4'd0});
        do_start(2, 1);
        chk("to_err_clear", err_o, 0);
        wait_req(30);
        chk("to_reissue_gap", last_req_cyc - prev_req_cyc, 9);
        chk("to_err_set", err_o, 1);
        step();
        weight_ack_i = 1'b1;
        step();
        weight_ack_i = 1'b0;
        pe_done_i = 1'b1;
        step();
        pe_done_i = 1'b0;
        chk("to_done", done_o, 1);
        chk("to_err_sticky", err_o, 1);
        repeat (2) step();
        do_start(0, 1);
        chk("to_err_cleared_by_start", err_o, 0);
        repeat (2) step();
`else
        chk("err_tied_low", err_o, 0);
`endif

        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1, "watchdog");
    end

endmodule
